// File: rtl/parity_seq_gen_if.sv
// Output stream of the parity sequence generator: value plus valid/ready handshake.
interface parity_seq_gen_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] num_out;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output num_out,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  num_out,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/parity_seq_gen.sv
// Emits COUNT consecutive even or odd numbers from a seed over a valid/ready stream,
// sequenced by an IDLE/GEN/DONE control FSM.
module parity_seq_gen #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                sel_odd,
  input  logic [WIDTH-1:0]    start_val,
  input  logic [CNT_W-1:0]    count,
  output logic                busy,
  output logic                done,
  parity_seq_gen_if.master    out_if
);

  typedef enum logic [1:0] {StIdle, StGen, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] num_q;
  logic             valid_q;
  logic [CNT_W-1:0] remaining_q;
  logic             busy_q;
  logic             done_q;

  logic handshake;
  assign handshake = valid_q && out_if.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      num_q       <= '0;
      valid_q     <= 1'b0;
      remaining_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (start) begin
            busy_q <= 1'b1;
            if (count != '0) begin
              state_q     <= StGen;
              valid_q     <= 1'b1;
              remaining_q <= count;
              // Parity is fixed by the first value; +2 steps preserve it.
              num_q       <= (start_val[0] == sel_odd) ? start_val : start_val + WIDTH'(1);
            end else begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end
          end
        end
        StGen: begin
          if (handshake) begin
            if (remaining_q > CNT_W'(1)) begin
              num_q       <= num_q + WIDTH'(2);
              remaining_q <= remaining_q - CNT_W'(1);
            end else begin
              valid_q     <= 1'b0;
              remaining_q <= '0;
              state_q     <= StDone;
              done_q      <= 1'b1;
            end
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign out_if.num_out   = num_q;
  assign out_if.out_valid = valid_q;
  assign busy             = busy_q;
  assign done             = done_q;

endmodule
